piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out transmitter that accepts N-bit words over a valid/ready handshake and drives them one bit per clock onto a serial link. It feeds the SISO shift-register receiver chain: with MSB_FIRST=1, a downstream N-deep shift-left register holds the transmitted word exactly after the N-th framed bit. A one-word holding buffer lets the link carry back-to-back words with no idle gap.

## Interface

- N, default 4: word width in bits; legal range N >= 2.
- MSB_FIRST, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N  parallel word; sampled only on an accept.
- in_valid  input  1  source offers in_data.
- in_ready  output  1  block can take a word; equals !hold_valid.
- serial_out  output  1  serial bit; registered.
- serial_frame  output  1  high while serial_out carries a data bit; registered.
- busy  output  1  serial_frame | hold_valid.

## Operation

- Accept = in_valid & in_ready at a rising edge. in_valid is not required to stay high after an unaccepted cycle; in_data may change freely while in_ready is low.
- State: shift register sh[N-1:0], bit counter cnt of width $clog2(N), holding register hold[N-1:0] with flag hold_valid, FSM {IDLE, SHIFT}.
- IDLE:
  - accept -> sh <= in_data, cnt <= 0, go to SHIFT; hold untouched.
  - no accept -> remain IDLE; sh stays at 0.
- SHIFT, cnt < N-1:
  - shift sh toward the output end: left when MSB_FIRST=1, right when 0. Zero-fill.
  - cnt <= cnt+1.
  - An accept writes hold and sets hold_valid.
- SHIFT, cnt == N-1 (last bit):
  - hold_valid -> sh <= hold, clear hold_valid, cnt <= 0, stay in SHIFT. An accept in the same cycle is impossible because in_ready=0.
  - else accept -> sh <= in_data, cnt <= 0, stay in SHIFT.
  - else -> sh <= 0, go to IDLE.
- Outputs:
  - serial_out = sh[N-1] when MSB_FIRST=1, else sh[0].
  - serial_frame = (state == SHIFT).
  - Outside a frame, serial_out is 0.
- Word order is strictly FIFO. No word is dropped or duplicated.

## Timing

- Reset values: serial_out=0, serial_frame=0, busy=0. in_ready=1 during and after reset because hold_valid=0. Reset clears sh, cnt, hold, hold_valid and sets state to IDLE.
- Latency: for a word accepted at edge k with the block idle, the first bit is valid from edge k through k+1. The frame spans exactly N cycles, ending after edge k+N.
- Throughput: one word per N cycles. With a word waiting in hold, frames are contiguous and serial_frame never drops between words.
- in_ready falls the cycle after a hold write. It rises the cycle after the last-bit edge that drains hold.
- Reset asserted mid-word: outputs go to 0 immediately and asynchronously. The in-flight word and the held word are discarded. No partial frame resumes after release.
- Simultaneous last-bit and accept with hold empty: the new word goes directly to sh (zero-gap path), not to hold.

## Structure

- Shared package serdes_pkg holds:
  - the FSM state encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - a function computing the counter width from N, shared with the receiver side.
- Single module; no sub-module is warranted. The hold buffer and shifter are each too small to justify separate modules.

## Test plan

- Reset: hold rst_n low for 3 cycles with in_valid=1 -> serial_out=0, serial_frame=0, busy=0, in_ready=1; no word is captured.
- N=4, MSB_FIRST=1, single word 4'b1011 -> frame is 4 cycles with bits 1,0,1,1. serial_frame falls afterwards. A loopback SISO (N=4, shift-left, clocked only during frame) holds 4'b1011.
- Back-to-back 4'hA, 4'h5, 4'hC with in_valid held high -> 12 contiguous frame cycles carrying 1010 0101 1100. in_ready is low while hold is occupied. Exactly three accepts occur.
- MSB_FIRST=0, word 4'b0001 -> serial bits 1,0,0,0. Then idle: serial_out=0, serial_frame=0.
- Async reset during bit 2 of 4'hA with 4'h5 held -> outputs are 0 within the reset cycle. After release: in_ready=1, busy=0, no frame until a new accept. A new word 4'h3 then transmits cleanly as 0,0,1,1.
- in_data toggling every cycle while in_ready=0 -> transmitted words equal only the accepted values, with no corruption.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link blocks: FSM state encoding and
// the bit-counter width helper used by both transmitter and receiver.
package serdes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer so
// consecutive words go out back-to-back with no idle gap between frames.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         serial_out,
  output logic         serial_frame,
  output logic         busy
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state, state_n;
  logic [N-1:0]   sh, sh_n;
  logic [N-1:0]   hold, hold_n;
  logic           hold_valid, hold_valid_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           accept;
  logic           last_bit;
  logic [N-1:0]   sh_shifted;

  assign in_ready     = !hold_valid;
  assign accept       = in_valid && in_ready;
  assign last_bit     = (cnt == CW'(N - 1));
  assign sh_shifted   = MSB_FIRST ? {sh[N-2:0], 1'b0} : {1'b0, sh[N-1:1]};

  // sh is cleared whenever idle, so the output end reads 0 outside a frame.
  assign serial_out   = MSB_FIRST ? sh[N-1] : sh[0];
  assign serial_frame = (state == ST_SHIFT);
  assign busy         = serial_frame || hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sh         <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    sh_n         = sh;
    cnt_n        = cnt;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sh_n    = in_data;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          sh_n  = sh_shifted;
          cnt_n = cnt + CW'(1);
          if (accept) begin
            hold_n       = in_data;
            hold_valid_n = 1'b1;
          end
        end else if (hold_valid) begin
          sh_n         = hold;
          hold_valid_n = 1'b0;
          cnt_n        = '0;
        end else if (accept) begin
          // Last bit with hold empty: load straight into the shifter.
          sh_n  = in_data;
          cnt_n = '0;
        end else begin
          sh_n    = '0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven bench for piso_serializer: MSB-first and LSB-first instances,
// a loopback shift-left receiver on the MSB-first link, and reset corners.
module tb_piso_serializer;

  typedef struct {
    logic       sel;   // 0: MSB-first instance, 1: LSB-first instance
    logic       v;
    logic [3:0] d;
    logic       out;
    logic       frame;
    logic       ready;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d_m = '0, d_l = '0;
  logic       v_m = 1'b0, v_l = 1'b0;
  logic       rdy_m, out_m, frm_m, busy_m;
  logic       rdy_l, out_l, frm_l, busy_l;
  logic [3:0] rx;
  int         acc_m;
  int         tests = 0;
  int         fails = 0;
  int         acc_base;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  piso_serializer #(.N(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(d_m), .in_valid(v_m), .in_ready(rdy_m),
    .serial_out(out_m), .serial_frame(frm_m), .busy(busy_m)
  );

  piso_serializer #(.N(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(d_l), .in_valid(v_l), .in_ready(rdy_l),
    .serial_out(out_l), .serial_frame(frm_l), .busy(busy_l)
  );

  // Downstream receiver: shift-left, clocked only while framed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx <= '0;
    else if (frm_m) rx <= {rx[2:0], out_m};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_m <= 0;
    else if (v_m && rdy_m) acc_m <= acc_m + 1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, required run to complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic v, input logic [3:0] d,
                     input logic out, input logic frame, input logic ready,
                     input logic busy);
    vec_t r;
    r.sel = sel; r.v = v; r.d = d;
    r.out = out; r.frame = frame; r.ready = ready; r.busy = busy;
    vecs.push_back(r);
  endtask

  task automatic flush(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      v_m = 1'b0; v_l = 1'b0;
      if (vecs[i].sel) begin v_l = vecs[i].v; d_l = vecs[i].d; end
      else             begin v_m = vecs[i].v; d_m = vecs[i].d; end
      @(posedge clk);
      #1;
      if (vecs[i].sel) begin
        check($sformatf("%s[%0d].serial_out", tag, i),   int'(out_l), int'(vecs[i].out));
        check($sformatf("%s[%0d].serial_frame", tag, i), int'(frm_l), int'(vecs[i].frame));
        check($sformatf("%s[%0d].in_ready", tag, i),     int'(rdy_l), int'(vecs[i].ready));
        check($sformatf("%s[%0d].busy", tag, i),         int'(busy_l), int'(vecs[i].busy));
      end else begin
        check($sformatf("%s[%0d].serial_out", tag, i),   int'(out_m), int'(vecs[i].out));
        check($sformatf("%s[%0d].serial_frame", tag, i), int'(frm_m), int'(vecs[i].frame));
        check($sformatf("%s[%0d].in_ready", tag, i),     int'(rdy_m), int'(vecs[i].ready));
        check($sformatf("%s[%0d].busy", tag, i),         int'(busy_m), int'(vecs[i].busy));
      end
    end
    vecs.delete();
    @(negedge clk);
    v_m = 1'b0; v_l = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles with in_valid asserted.
    v_m = 1'b1; d_m = 4'hF; v_l = 1'b1; d_l = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst.serial_out", int'(out_m), 0);
    check("rst.serial_frame", int'(frm_m), 0);
    check("rst.busy", int'(busy_m), 0);
    check("rst.in_ready", int'(rdy_m), 1);
    check("rst.lsb_frame", int'(frm_l), 0);
    @(negedge clk);
    v_m = 1'b0; v_l = 1'b0; rst_n = 1'b1;
    add(0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    flush("post_rst");
    check("post_rst.accepts", acc_m, 0);

    // Single word 1011, MSB first.
    add(0, 1, 4'hB, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    flush("single");
    check("single.rx", int'(rx), 11);

    // Back-to-back A,5,C; in_data toggles while in_ready is low.
    acc_base = acc_m;
    add(0, 1, 4'hA, 1, 1, 1, 1);
    add(0, 1, 4'h5, 0, 1, 0, 1);
    add(0, 1, 4'hF, 1, 1, 0, 1);
    add(0, 1, 4'h0, 0, 1, 0, 1);
    add(0, 1, 4'h7, 0, 1, 1, 1);
    add(0, 1, 4'hC, 1, 1, 0, 1);
    add(0, 0, 4'hF, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1);
    add(0, 0, 4'hF, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'hF, 0, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    flush("b2b");
    check("b2b.accepts", acc_m - acc_base, 3);
    check("b2b.rx", int'(rx), 12);

    // Accept on the last-bit edge with hold empty: zero-gap direct load.
    add(0, 1, 4'h6, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 1, 4'h9, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    flush("zgap");
    check("zgap.rx", int'(rx), 9);

    // LSB-first: 0001 -> 1,0,0,0 ; 1101 -> 1,0,1,1.
    add(1, 1, 4'h1, 1, 1, 1, 1);
    add(1, 0, 4'h0, 0, 1, 1, 1);
    add(1, 0, 4'h0, 0, 1, 1, 1);
    add(1, 0, 4'h0, 0, 1, 1, 1);
    add(1, 0, 4'h0, 0, 0, 1, 0);
    add(1, 1, 4'hD, 1, 1, 1, 1);
    add(1, 0, 4'h0, 0, 1, 1, 1);
    add(1, 0, 4'h0, 1, 1, 1, 1);
    add(1, 0, 4'h0, 1, 1, 1, 1);
    add(1, 0, 4'h0, 0, 0, 1, 0);
    flush("lsb");

    // Async reset mid-word with 5 held.
    add(0, 1, 4'hA, 1, 1, 1, 1);
    add(0, 1, 4'h5, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1);
    foreach (vecs[i]) begin
      @(negedge clk);
      v_m = vecs[i].v; d_m = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("mid[%0d].serial_out", i), int'(out_m), int'(vecs[i].out));
      check($sformatf("mid[%0d].in_ready", i),   int'(rdy_m), int'(vecs[i].ready));
    end
    vecs.delete();
    #2 rst_n = 1'b0;
    #1;
    check("midrst.serial_out", int'(out_m), 0);
    check("midrst.serial_frame", int'(frm_m), 0);
    check("midrst.busy", int'(busy_m), 0);
    check("midrst.in_ready", int'(rdy_m), 1);
    @(negedge clk);
    v_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add(0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 1, 4'h3, 0, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 0, 1, 0);
    flush("after_rst");
    check("after_rst.rx", int'(rx), 3);
    check("after_rst.accepts", acc_m, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
